// File: rtl/reservoir_pkg.sv
// reservoir_pkg: level codes, scheduler states and sensor-code validity check
package reservoir_pkg;
  localparam logic [2:0] LVL_EMPTY = 3'b000;
  localparam logic [2:0] LVL_LOW = 3'b001;
  localparam logic [2:0] LVL_MID = 3'b011;
  localparam logic [2:0] LVL_FULL = 3'b111;
  typedef enum logic [1:0] {IDLE, UP, STEADY, DOWN} state_t;
  function automatic logic is_valid_level(input logic [2:0] code);
    return code inside {LVL_EMPTY, LVL_LOW, LVL_MID, LVL_FULL};
  endfunction
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: accepts a sensor code after DEBOUNCE_CYC identical samples; flags invalid codes
module sensor_debounce
  import reservoir_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] s,
  output logic [2:0] lvl,
  output logic       fault,
  output logic       seen
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [2:0] prev;
  logic [CW-1:0] cnt, cnt_nxt;
  always_comb cnt_nxt = (s != prev) ? CW'(1) : (cnt == CW'(DEBOUNCE_CYC)) ? cnt : cnt + 1'b1;
  // seen gates demand until the first valid code is accepted, so reset lvl=000 cannot start pumps
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      cnt <= '0;
      lvl <= '0;
      fault <= 1'b0;
      seen <= 1'b0;
    end else begin
      prev <= s;
      cnt <= cnt_nxt;
      if (cnt_nxt == CW'(DEBOUNCE_CYC)) begin
        if (is_valid_level(s)) begin
          lvl <= s;
          fault <= 1'b0;
          seen <= 1'b1;
        end else begin
          fault <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/reservoir_pump_scheduler.sv
// reservoir_pump_scheduler: staggers fill pumps on/off from debounced level demand
// with hold timing and lead-pump rotation for wear levelling
module reservoir_pump_scheduler
  import reservoir_pkg::*;
#(
  parameter int NUM_PUMPS = 3,
  parameter int DEBOUNCE_CYC = 4,
  parameter int STAGGER_CYC = 2,
  parameter int MIN_ON_CYC = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   s,
  output logic [NUM_PUMPS-1:0]         pump_en,
  output logic [$clog2(NUM_PUMPS+1)-1:0] run_cnt,
  output logic [$clog2(NUM_PUMPS)-1:0] lead,
  output logic                         busy,
  output logic                         fault
);
  localparam int RW = $clog2(NUM_PUMPS + 1);
  localparam int LW = $clog2(NUM_PUMPS);
  localparam int HMAX = (STAGGER_CYC > MIN_ON_CYC) ? STAGGER_CYC : MIN_ON_CYC;
  localparam int HW = $clog2(HMAX + 1);
  logic [2:0] lvl;
  logic seen, up_ok, dn_ok;
  logic [RW-1:0] demand, run_nxt;
  logic [HW-1:0] hold;
  logic [NUM_PUMPS-1:0] pe_nxt;
  state_t state, state_nxt;
  sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk(clk), .reset(reset), .s(s), .lvl(lvl), .fault(fault), .seen(seen)
  );
  assign demand = seen ? RW'(3 - $countones(lvl)) : '0;
  // hold is cleared on the changing edge, so hold+1 is the number of edges since that change
  assign up_ok = (run_cnt < demand) && (int'(hold) + 1 >= STAGGER_CYC);
  assign dn_ok = (run_cnt > demand) && (int'(hold) + 1 >= MIN_ON_CYC);
  assign run_nxt = up_ok ? run_cnt + 1'b1 : dn_ok ? run_cnt - 1'b1 : run_cnt;
  assign state_nxt = (run_nxt == demand) ? ((run_nxt == '0) ? IDLE : STEADY) : (run_nxt < demand) ? UP : DOWN;
  assign busy = (state == UP) || (state == DOWN);
  // pump j is on when its distance from lead in start order is below the running count
  always_comb begin
    pe_nxt = '0;
    for (int j = 0; j < NUM_PUMPS; j++)
      pe_nxt[j] = ((j >= int'(lead)) ? j - int'(lead) : j + NUM_PUMPS - int'(lead)) < int'(run_nxt);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pump_en <= '0;
      run_cnt <= '0;
      lead <= '0;
      hold <= HW'(HMAX);
      state <= IDLE;
    end else begin
      pump_en <= pe_nxt;
      run_cnt <= run_nxt;
      state <= state_nxt;
      hold <= (run_nxt != run_cnt) ? '0 : (hold == HW'(HMAX)) ? hold : hold + 1'b1;
      if (run_cnt != '0 && run_nxt == '0)
        lead <= (lead == LW'(NUM_PUMPS - 1)) ? '0 : lead + 1'b1;
    end
  end
endmodule

// File: tb/tb_reservoir_pump_scheduler.sv
// tb_reservoir_pump_scheduler: scoreboard bench with per-cycle ramp sequences and a phase table
module tb_reservoir_pump_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] s = 3'b111;
  logic [2:0] pump_en;
  logic [1:0] run_cnt;
  logic [1:0] lead;
  logic busy, fault;
  typedef struct packed {
    logic [2:0] pe;
    logic [1:0] rc;
    logic [1:0] ld;
    logic bsy;
    logic flt;
  } exp_t;
  typedef struct {
    logic [2:0] s;
    int cyc;
    exp_t e;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[10];
  int n_cmp = 0;
  int n_bad = 0;
  reservoir_pump_scheduler dut (
    .clk(clk), .reset(reset), .s(s), .pump_en(pump_en), .run_cnt(run_cnt),
    .lead(lead), .busy(busy), .fault(fault)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(logic [2:0] pe, logic [1:0] rc, logic [1:0] ld, logic b, logic f);
    exp_t e;
    e.pe = pe;
    e.rc = rc;
    e.ld = ld;
    e.bsy = b;
    e.flt = f;
    return e;
  endfunction
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic check(string name);
    exp_t a, e;
    a = {pump_en, run_cnt, lead, busy, fault};
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = sb.pop_front();
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got pe=%b rc=%0d ld=%0d busy=%b fault=%b, want pe=%b rc=%0d ld=%0d busy=%b fault=%b",
               name, a.pe, a.rc, a.ld, a.bsy, a.flt, e.pe, e.rc, e.ld, e.bsy, e.flt);
    end
  endtask
  initial begin
    tbl[0] = '{3'b001, 12, mk(3'b110, 2'd2, 2'd1, 1'b0, 1'b0)};
    tbl[1] = '{3'b111, 30, mk(3'b000, 2'd0, 2'd2, 1'b0, 1'b0)};
    tbl[2] = '{3'b001, 3, mk(3'b000, 2'd0, 2'd2, 1'b0, 1'b0)};
    tbl[3] = '{3'b111, 10, mk(3'b000, 2'd0, 2'd2, 1'b0, 1'b0)};
    tbl[4] = '{3'b011, 10, mk(3'b100, 2'd1, 2'd2, 1'b0, 1'b0)};
    tbl[5] = '{3'b101, 4, mk(3'b100, 2'd1, 2'd2, 1'b0, 1'b1)};
    tbl[6] = '{3'b101, 6, mk(3'b100, 2'd1, 2'd2, 1'b0, 1'b1)};
    tbl[7] = '{3'b011, 3, mk(3'b100, 2'd1, 2'd2, 1'b0, 1'b1)};
    tbl[8] = '{3'b011, 1, mk(3'b100, 2'd1, 2'd2, 1'b0, 1'b0)};
    tbl[9] = '{3'b000, 5, mk(3'b101, 2'd2, 2'd2, 1'b1, 1'b0)};
    tick(2);
    sb.push_back(mk(3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    check("reset");
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      sb.push_back(mk(3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
      check("full_idle");
    end
    s = 3'b000;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      sb.push_back(mk(n < 5 ? 3'b000 : n < 7 ? 3'b001 : n < 9 ? 3'b011 : 3'b111,
                      n < 5 ? 2'd0 : n < 7 ? 2'd1 : n < 9 ? 2'd2 : 2'd3,
                      2'd0, (n >= 5) && (n < 9), 1'b0));
      check("ramp_up");
    end
    s = 3'b111;
    for (int m = 1; m <= 24; m++) begin
      tick(1);
      sb.push_back(mk(m < 5 ? 3'b111 : m < 13 ? 3'b011 : m < 21 ? 3'b001 : 3'b000,
                      m < 5 ? 2'd3 : m < 13 ? 2'd2 : m < 21 ? 2'd1 : 2'd0,
                      m < 21 ? 2'd0 : 2'd1, (m >= 5) && (m < 21), 1'b0));
      check("ramp_down");
    end
    for (int i = 0; i < 10; i++) begin
      s = tbl[i].s;
      sb.push_back(tbl[i].e);
      tick(tbl[i].cyc);
      check($sformatf("table_row%0d", i));
    end
    reset = 1'b1;
    tick(1);
    sb.push_back(mk(3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
    check("reset_mid_ramp");
    reset = 1'b0;
    tick(5);
    sb.push_back(mk(3'b001, 2'd1, 2'd0, 1'b1, 1'b0));
    check("restart_after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reservoir_pump_scheduler.md
Name: reservoir_pump_scheduler

Overview:
Sequences the fill pumps that feed the water reservoir from the same three thermometer-coded level sensors s[3:1]. It debounces the sensor code, converts the level into a pump demand, and ramps pumps on and off one at a time. Each pump change is spaced by a stagger time and a minimum hold time. A lead pointer rotates which physical pump starts first, so pump wear is levelled. It sits between the sensor inputs and the pump contactor drivers, beside the flow-rate indicator logic.

Parameters:
NUM_PUMPS, 3, number of physical pumps (legal 3..8)
DEBOUNCE_CYC, 4, consecutive identical sensor samples required before a code is accepted
STAGGER_CYC, 2, minimum cycles between two consecutive pump starts
MIN_ON_CYC, 8, minimum cycles after any run_cnt change before a pump may be stopped

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
s  input  3  level sensors s[3:1]; 000 below s1, 001, 011, 111 above s3
pump_en  output  NUM_PUMPS  one enable per pump
run_cnt  output  $clog2(NUM_PUMPS+1)  number of pumps currently enabled
lead  output  $clog2(NUM_PUMPS)  index of the first pump in the start order
busy  output  1  high while ramping (state UP or DOWN)
fault  output  1  high while an accepted invalid sensor code is present

Behaviour:
- Reset: clk and reset as decided — reset is synchronous and active-high; clk is the clock. On reset: pump_en=0, run_cnt=0, lead=0, busy=0, fault=0, accepted level lvl=000, debounce count=0, hold counter preset to saturated value, state=IDLE. Reset asserted mid-ramp drops all pumps on the next edge.
- Debounce: raw s is compared with the previous sample, and the counter restarts at 1 on any change. Once the same code has been seen for DEBOUNCE_CYC consecutive cycles, it is accepted.
  - If the accepted code is valid (000/001/011/111): lvl is updated and fault is cleared.
  - If the accepted code is invalid (010, 100, 101, 110): fault=1 and lvl holds its last valid value.
- Demand = 3 - popcount(lvl), so 000 gives 3, 001 gives 2, 011 gives 1, and 111 gives 0. Demand is always ≤ NUM_PUMPS; pumps beyond the third are rotation spares.
- Hold counter: cleared to 0 on every run_cnt change, increments each cycle, and saturates at max(STAGGER_CYC, MIN_ON_CYC).
- Pump mapping: pump_en[(lead+i) mod NUM_PUMPS]=1 for i in 0..run_cnt-1; all other bits are 0. Starts therefore go in lead order and stops go in reverse start order (last started stops first).
- FSM (registered state, one run_cnt change per cycle at most):
  - IDLE: run_cnt=0. Goes to UP when demand>0.
  - UP: each cycle with run_cnt<demand and hold≥STAGGER_CYC, run_cnt+1. Goes to STEADY when run_cnt==demand, and to DOWN if demand drops below run_cnt.
  - STEADY: goes to UP if demand>run_cnt, and to DOWN if demand<run_cnt.
  - DOWN: each cycle with run_cnt>demand and hold≥MIN_ON_CYC, run_cnt-1. Goes to STEADY when run_cnt==demand and demand>0, to IDLE when run_cnt reaches 0, and to UP if demand rises above run_cnt.
- Lead rotation: on the DOWN→IDLE transition, lead ← (lead+1) mod NUM_PUMPS. lead never changes while any pump is on.
- Latency: from the first cycle of a stable new valid code to the pump_en change is DEBOUNCE_CYC+1 edges when the hold constraint is already met.
- Simultaneous events: a demand change mid-ramp retargets immediately; the hold constraints still apply.
- Fault: pumps keep tracking the last valid lvl, so a sensor fault never forces a pump change.

Decomposition:
- Package reservoir_pkg: level codes LVL_EMPTY=3'b000, LVL_LOW=3'b001, LVL_MID=3'b011, LVL_FULL=3'b111; state enum {IDLE, UP, STEADY, DOWN}; function is_valid_level().
- Sub-module sensor_debounce (parameter DEBOUNCE_CYC): inputs s, outputs lvl and fault. Instantiated once.

Test Plan:
- Reset, then hold s=111 for 20 cycles → pump_en=000, run_cnt=0, busy=0, fault=0 throughout.
- s=000 held from cycle 0 → lvl accepted after 4 cycles. pump_en goes 001, then 011 two cycles later, then 111 two cycles after that. busy falls when run_cnt=3.
- From 3 running, set s=111 → stops are spaced ≥8 cycles apart in the order pump2, pump1, pump0. On reaching IDLE, lead=1. The next s=001 starts pump1 first, then pump2 (pump_en 010 → 110).
- Glitch s=001 for 3 cycles within a steady 111 → no lvl change and no pump change.
- s=101 held 4 cycles while run_cnt=1 → fault=1 and pump_en unchanged. Return to s=011 for 4 cycles → fault=0.
- Assert reset during a ramp with run_cnt=2 → the next edge gives pump_en=0, run_cnt=0, lead=0, state IDLE.
